apb_cmd_sequencer: RTL and testbench

APB_CMD_SEQUENCER -- requirements
Module: apb_cmd_sequencer

---
 rtl/apb_cmd_sequencer_if.sv | 26 ++
 rtl/apb_cmd_sequencer.sv | 130 +++++++++++++
 tb/tb_apb_cmd_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_sequencer_if.sv
// Command/status bundle between the APB register block and the sequencer.
// master: register block and sink side; slave: the sequencer.
interface apb_cmd_sequencer_if;
  logic        start;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic [7:0]  ilen;
  logic        abort;
  logic [1:0]  status;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_last;
  logic        done_irq;

  modport master (
    output start, iaddr, idata, ilen, abort, cmd_ready,
    input  status, cmd_valid, cmd_addr, cmd_data, cmd_last, done_irq
  );

  modport slave (
    input  start, iaddr, idata, ilen, abort, cmd_ready,
    output status, cmd_valid, cmd_addr, cmd_data, cmd_last, done_irq
  );
endinterface

// File: rtl/apb_cmd_sequencer.sv
// Expands one (base, seed, len) command into len address/data beats.
// Optional stall timeout: define CMD_SEQ_TIMEOUT_EN.
module apb_cmd_sequencer #(
  parameter int unsigned ADDR_STRIDE    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic               io_systemClk,
  input logic               io_systemReset,
  apb_cmd_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_e;

  localparam logic [31:0] STRIDE = 32'(ADDR_STRIDE);

  state_e      state_q, state_d;
  logic        start_q, start_d;
  logic [31:0] base_q, base_d;
  logic [31:0] seed_q, seed_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  idx_q, idx_d;
  logic        irq_q, irq_d;

  logic start_edge;
  logic in_run;
  logic is_last;
  logic fire;
  logic stall;
  logic timeout;

  assign start_edge = bus.start & ~start_q;
  assign in_run     = (state_q == RUN);
  assign is_last    = in_run && (idx_q == len_q - 8'd1);
  assign fire       = in_run & bus.cmd_ready;
  assign stall      = in_run & ~bus.cmd_ready;

  assign bus.status    = state_q;
  assign bus.cmd_valid = in_run;
  assign bus.cmd_last  = is_last;
  assign bus.cmd_addr  = base_q + 32'(idx_q) * STRIDE;
  assign bus.cmd_data  = seed_q + 32'(idx_q);
  assign bus.done_irq  = irq_q;

`ifdef CMD_SEQ_TIMEOUT_EN
  localparam logic [31:0] STALL_LIM = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] stall_q, stall_d;

  assign timeout = stall && (stall_q == STALL_LIM);

  always_comb begin
    stall_d = 32'd0;
    if (in_run && state_d == RUN && !fire)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) stall_q <= 32'd0;
    else                stall_q <= stall_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    start_d = bus.start;
    base_d  = base_q;
    seed_d  = seed_q;
    len_d   = len_q;
    idx_d   = idx_q;
    irq_d   = 1'b0;
    unique case (state_q)
      RUN: begin
        // abort and timeout both win over a same-cycle transfer
        if (bus.abort || timeout) begin
          state_d = ERR;
          irq_d   = 1'b1;
        end else if (fire) begin
          if (is_last) begin
            state_d = DONE;
            irq_d   = 1'b1;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: begin
        if (start_edge) begin
          base_d = bus.iaddr;
          seed_d = bus.idata;
          len_d  = bus.ilen;
          idx_d  = 8'd0;
          if (bus.ilen == 8'd0) begin
            state_d = DONE;
            irq_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      state_q <= IDLE;
      start_q <= 1'b1;
      base_q  <= 32'd0;
      seed_q  <= 32'd0;
      len_q   <= 8'd0;
      idx_q   <= 8'd0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      base_q  <= base_d;
      seed_q  <= seed_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed bench for apb_cmd_sequencer: bursts, stalls, abort, wrap, reset,
// and stall timeout (build with CMD_SEQ_TIMEOUT_EN for the timeout case).
module tb_apb_cmd_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;
  int   xfers;

  always #5 clk = ~clk;

  apb_cmd_sequencer_if bus ();

  apb_cmd_sequencer #(
    .ADDR_STRIDE   (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .io_systemClk  (clk),
    .io_systemReset(rst),
    .bus           (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic arm(input logic [31:0] a, input logic [31:0] d,
                     input logic [7:0] l);
    bus.start = 1'b0;
    step();
    bus.iaddr = a;
    bus.idata = d;
    bus.ilen  = l;
    bus.start = 1'b1;
    step();
  endtask

  initial begin
    logic rdy_pat [6];
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bus.start     = 1'b0;
    bus.iaddr     = 32'd0;
    bus.idata     = 32'd0;
    bus.ilen      = 8'd0;
    bus.abort     = 1'b0;
    bus.cmd_ready = 1'b0;

    step();
    step();
    check("rst_status", 32'(bus.status), 32'd0);
    check("rst_valid", 32'(bus.cmd_valid), 32'd0);
    check("rst_last", 32'(bus.cmd_last), 32'd0);
    check("rst_irq", 32'(bus.done_irq), 32'd0);
    check("rst_addr", bus.cmd_addr, 32'd0);
    check("rst_data", bus.cmd_data, 32'd0);
    rst = 1'b0;

    // four-beat burst, ready held high
    bus.cmd_ready = 1'b1;
    arm(32'h1000, 32'hA0, 8'd4);
    for (int i = 0; i < 4; i++) begin
      check("b4_valid", 32'(bus.cmd_valid), 32'd1);
      check("b4_addr", bus.cmd_addr, 32'h1000 + 32'(i) * 32'd4);
      check("b4_data", bus.cmd_data, 32'hA0 + 32'(i));
      check("b4_last", 32'(bus.cmd_last), 32'(i == 3));
      step();
    end
    check("b4_status", 32'(bus.status), 32'd2);
    check("b4_irq", 32'(bus.done_irq), 32'd1);
    check("b4_valid_off", 32'(bus.cmd_valid), 32'd0);
    step();
    check("b4_irq_once", 32'(bus.done_irq), 32'd0);
    check("b4_hold", 32'(bus.status), 32'd2);

    // three beats with a stalling sink
    arm(32'h2000, 32'h10, 8'd3);
    xfers = 0;
    for (int k = 0; k < 6; k++) begin
      bus.cmd_ready = rdy_pat[k];
      check("st_valid", 32'(bus.cmd_valid), 32'd1);
      check("st_addr", bus.cmd_addr, 32'h2000 + 32'(xfers) * 32'd4);
      check("st_data", bus.cmd_data, 32'h10 + 32'(xfers));
      check("st_last", 32'(bus.cmd_last), 32'(xfers == 2));
      if (bus.cmd_valid && bus.cmd_ready) xfers++;
      step();
    end
    check("st_xfers", 32'(xfers), 32'd3);
    check("st_status", 32'(bus.status), 32'd2);
    check("st_irq", 32'(bus.done_irq), 32'd1);

    // zero-length command
    bus.cmd_ready = 1'b1;
    bus.start = 1'b0;
    step();
    bus.ilen  = 8'd0;
    bus.start = 1'b1;
    check("z_valid_pre", 32'(bus.cmd_valid), 32'd0);
    step();
    check("z_valid", 32'(bus.cmd_valid), 32'd0);
    check("z_status", 32'(bus.status), 32'd2);
    check("z_irq", 32'(bus.done_irq), 32'd1);
    step();
    check("z_irq_once", 32'(bus.done_irq), 32'd0);

    // abort on the third beat, simultaneous with ready
    arm(32'h3000, 32'h0, 8'd8);
    step();
    step();
    check("ab_addr", bus.cmd_addr, 32'h3008);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("ab_status", 32'(bus.status), 32'd3);
    check("ab_valid", 32'(bus.cmd_valid), 32'd0);
    check("ab_irq", 32'(bus.done_irq), 32'd1);

    // restart edge during RUN must be ignored
    bus.cmd_ready = 1'b0;
    arm(32'h4000, 32'h55, 8'd3);
    check("rr_addr0", bus.cmd_addr, 32'h4000);
    arm(32'h5000, 32'h99, 8'd9);
    check("rr_status", 32'(bus.status), 32'd1);
    check("rr_addr", bus.cmd_addr, 32'h4000);
    check("rr_data", bus.cmd_data, 32'h55);
    bus.cmd_ready = 1'b1;
    step();
    step();
    check("rr_last", 32'(bus.cmd_last), 32'd1);
    check("rr_addr2", bus.cmd_addr, 32'h4008);
    step();
    check("rr_done", 32'(bus.status), 32'd2);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("ab_ignored", 32'(bus.status), 32'd2);

    // address wrap
    arm(32'hFFFF_FFFC, 32'h7, 8'd2);
    check("w_addr0", bus.cmd_addr, 32'hFFFF_FFFC);
    step();
    check("w_addr1", bus.cmd_addr, 32'h0000_0000);
    check("w_data1", bus.cmd_data, 32'h8);
    step();
    check("w_status", 32'(bus.status), 32'd2);

    // reset mid-RUN, start held high through reset
    bus.cmd_ready = 1'b0;
    arm(32'h6000, 32'h1, 8'd5);
    check("r_run", 32'(bus.status), 32'd1);
    rst = 1'b1;
    step();
    check("r_status", 32'(bus.status), 32'd0);
    check("r_valid", 32'(bus.cmd_valid), 32'd0);
    check("r_addr", bus.cmd_addr, 32'd0);
    rst = 1'b0;
    step();
    check("r_no_start", 32'(bus.status), 32'd0);

    // stall timeout
    arm(32'h7000, 32'h0, 8'd2);
    check("to_run", 32'(bus.status), 32'd1);
`ifdef CMD_SEQ_TIMEOUT_EN
    repeat (15) step();
    check("to_before", 32'(bus.status), 32'd1);
    step();
    check("to_status", 32'(bus.status), 32'd3);
    check("to_irq", 32'(bus.done_irq), 32'd1);
`else
    repeat (10000) step();
    check("to_none", 32'(bus.status), 32'd1);
    check("to_valid", 32'(bus.cmd_valid), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
